// File: rtl/gpio_pad_pkg.sv
// Shared types and default sizing for the GPIO pad responder.
package gpio_pad_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_HOLD_WIDTH = 8;
    localparam int DEF_PAT_DEPTH  = 4;
    localparam int DEF_CAP_DEPTH  = 8;

    typedef enum logic {
        PAD_IDLE = 1'b0,
        PAD_HOLD = 1'b1
    } pad_state_t;

    // Capture FIFO entry layout at the default pin width (data in the upper half).
    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] data;
        logic [DEF_DATA_WIDTH-1:0] mask;
    } cap_entry_t;

endpackage

// File: rtl/gpio_pad_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers and async active-high reset.
// The caller owns write legality, so a write into a full FIFO alongside a pop is allowed.
module gpio_pad_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_rd;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_rd    = rd_en && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/gpio_pad_responder.sv
// Pin-side responder for the GPIO pad bus: pattern/loopback driver plus output-change capture.
// Define GPIO_PAD_CAPTURE_EN to build the capture path; otherwise cap_* outputs are tied low.
module gpio_pad_responder
    import gpio_pad_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int HOLD_WIDTH = DEF_HOLD_WIDTH,
    parameter int PAT_DEPTH  = DEF_PAT_DEPTH,
    parameter int CAP_DEPTH  = DEF_CAP_DEPTH
) (
    input  logic                  pclk,
    input  logic                  p_reset,
    input  logic [DATA_WIDTH-1:0] n_gpio_pin_oe,
    input  logic [DATA_WIDTH-1:0] gpio_pin_out,
    output logic [DATA_WIDTH-1:0] gpio_pin_in,
    input  logic                  loopback_en,
    input  logic                  pat_valid,
    output logic                  pat_ready,
    input  logic [DATA_WIDTH-1:0] pat_data,
    input  logic [HOLD_WIDTH-1:0] pat_hold,
    output logic                  cap_valid,
    input  logic                  cap_ready,
    output logic [DATA_WIDTH-1:0] cap_data,
    output logic [DATA_WIDTH-1:0] cap_mask,
    output logic                  cap_overflow,
    output logic                  busy
);

    localparam int PAT_W = HOLD_WIDTH + DATA_WIDTH;

    logic             pat_full, pat_empty, pat_push, pat_pop;
    logic [PAT_W-1:0] pat_head;

    pad_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] drive_q, drive_d;
    logic [HOLD_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] gpio_pin_in_q, gpio_pin_in_d;
    logic [DATA_WIDTH-1:0] loop_sel;

    // A full pattern FIFO refuses pushes even when the FSM pops in the same cycle.
    assign pat_ready = !pat_full;
    assign pat_push  = pat_valid && !pat_full;

    gpio_pad_fifo #(
        .WIDTH (PAT_W),
        .DEPTH (PAT_DEPTH)
    ) u_pat_fifo (
        .clk     (pclk),
        .rst     (p_reset),
        .wr_en   (pat_push),
        .wr_data ({pat_hold, pat_data}),
        .rd_en   (pat_pop),
        .rd_data (pat_head),
        .full    (pat_full),
        .empty   (pat_empty)
    );

    always_comb begin
        state_d = state_q;
        drive_d = drive_q;
        cnt_d   = cnt_q;
        pat_pop = 1'b0;
        unique case (state_q)
            PAD_IDLE: begin
                if (!pat_empty) begin
                    pat_pop = 1'b1;
                    drive_d = pat_head[DATA_WIDTH-1:0];
                    cnt_d   = pat_head[PAT_W-1:DATA_WIDTH];
                    state_d = PAD_HOLD;
                end
            end
            PAD_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - HOLD_WIDTH'(1);
                end else if (!pat_empty) begin
                    pat_pop = 1'b1;
                    drive_d = pat_head[DATA_WIDTH-1:0];
                    cnt_d   = pat_head[PAT_W-1:DATA_WIDTH];
                end else begin
                    state_d = PAD_IDLE;
                end
            end
            default: state_d = PAD_IDLE;
        endcase

        loop_sel      = {DATA_WIDTH{loopback_en}} & ~n_gpio_pin_oe;
        gpio_pin_in_d = (gpio_pin_out & loop_sel) | (drive_q & ~loop_sel);
    end

    always_ff @(posedge pclk or posedge p_reset) begin
        if (p_reset) begin
            state_q       <= PAD_IDLE;
            drive_q       <= '0;
            cnt_q         <= '0;
            gpio_pin_in_q <= '0;
        end else begin
            state_q       <= state_d;
            drive_q       <= drive_d;
            cnt_q         <= cnt_d;
            gpio_pin_in_q <= gpio_pin_in_d;
        end
    end

    assign gpio_pin_in = gpio_pin_in_q;
    assign busy        = (state_q == PAD_HOLD) || !pat_empty;

`ifdef GPIO_PAD_CAPTURE_EN
    logic [DATA_WIDTH-1:0]   drv_q, drv_d, msk_q, msk_d;
    logic                    overflow_q, overflow_d;
    logic                    cap_event, cap_push, cap_pop, cap_full, cap_empty;
    logic [2*DATA_WIDTH-1:0] cap_head;

    // A write into a full FIFO only succeeds when the consumer frees a slot in the same cycle.
    always_comb begin
        drv_d      = gpio_pin_out & ~n_gpio_pin_oe;
        msk_d      = ~n_gpio_pin_oe;
        cap_event  = (drv_d != drv_q) || (msk_d != msk_q);
        cap_pop    = cap_ready && !cap_empty;
        cap_push   = cap_event && (!cap_full || cap_pop);
        overflow_d = overflow_q || (cap_event && !cap_push);
    end

    always_ff @(posedge pclk or posedge p_reset) begin
        if (p_reset) begin
            drv_q      <= '0;
            msk_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            drv_q      <= drv_d;
            msk_q      <= msk_d;
            overflow_q <= overflow_d;
        end
    end

    gpio_pad_fifo #(
        .WIDTH (2*DATA_WIDTH),
        .DEPTH (CAP_DEPTH)
    ) u_cap_fifo (
        .clk     (pclk),
        .rst     (p_reset),
        .wr_en   (cap_push),
        .wr_data ({drv_d, msk_d}),
        .rd_en   (cap_pop),
        .rd_data (cap_head),
        .full    (cap_full),
        .empty   (cap_empty)
    );

    assign cap_valid    = !cap_empty;
    assign cap_data     = cap_valid ? cap_head[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
    assign cap_mask     = cap_valid ? cap_head[DATA_WIDTH-1:0] : '0;
    assign cap_overflow = overflow_q;
`else
    logic        unused_cap_ready;
    logic [31:0] unused_cap_depth;

    assign unused_cap_ready = cap_ready;
    assign unused_cap_depth = 32'(CAP_DEPTH);
    assign cap_valid        = 1'b0;
    assign cap_data         = '0;
    assign cap_mask         = '0;
    assign cap_overflow     = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_pad_responder.sv
// Scoreboard bench for gpio_pad_responder: a cycle reference model queues expectations,
// a negedge monitor consumes them, and directed scenarios add targeted checks.
module tb_gpio_pad_responder;
    import gpio_pad_pkg::*;

    localparam int DW = 32;
    localparam int HW = 8;
    localparam int PD = 4;
    localparam int CD = 8;
`ifdef GPIO_PAD_CAPTURE_EN
    localparam int CAP_ON = 1;
`else
    localparam int CAP_ON = 0;
`endif

    logic          pclk;
    logic          p_reset;
    logic [DW-1:0] n_gpio_pin_oe, gpio_pin_out, gpio_pin_in;
    logic          loopback_en, pat_valid, pat_ready;
    logic [DW-1:0] pat_data;
    logic [HW-1:0] pat_hold;
    logic          cap_valid, cap_ready, cap_overflow, busy;
    logic [DW-1:0] cap_data, cap_mask;

    gpio_pad_responder #(
        .DATA_WIDTH (DW),
        .HOLD_WIDTH (HW),
        .PAT_DEPTH  (PD),
        .CAP_DEPTH  (CD)
    ) dut (
        .pclk          (pclk),
        .p_reset       (p_reset),
        .n_gpio_pin_oe (n_gpio_pin_oe),
        .gpio_pin_out  (gpio_pin_out),
        .gpio_pin_in   (gpio_pin_in),
        .loopback_en   (loopback_en),
        .pat_valid     (pat_valid),
        .pat_ready     (pat_ready),
        .pat_data      (pat_data),
        .pat_hold      (pat_hold),
        .cap_valid     (cap_valid),
        .cap_ready     (cap_ready),
        .cap_data      (cap_data),
        .cap_mask      (cap_mask),
        .cap_overflow  (cap_overflow),
        .busy          (busy)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int checks   = 0;
    int failures = 0;
    int cap_pops = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Reference model: queued words, current word with remaining extra cycles, captured changes.
    typedef struct packed {
        logic [HW-1:0] hold;
        logic [DW-1:0] data;
    } pat_t;

    typedef struct {
        logic [DW-1:0] pin;
        logic          busy;
        logic          ready;
    } cyc_t;

    pat_t          pq[$];
    cyc_t          cycq[$];
    cap_entry_t    capq[$];
    logic [DW-1:0] m_drive;
    int            m_left;
    bit            m_holding;
    int            m_cap_count;
    bit            m_ovf;
    logic [DW-1:0] m_prev_drv, m_prev_msk;

    logic [DW-1:0] md_lsel, md_drv, md_msk;
    bit            md_accept, md_cpop;
    cyc_t          md_e;
    cap_entry_t    md_ce;

    always @(posedge pclk) begin
        if (p_reset) begin
            pq.delete();
            capq.delete();
            cycq.delete();
            m_drive     = '0;
            m_left      = 0;
            m_holding   = 1'b0;
            m_cap_count = 0;
            m_ovf       = 1'b0;
            m_prev_drv  = '0;
            m_prev_msk  = '0;
        end else begin
            md_lsel   = {DW{loopback_en}} & ~n_gpio_pin_oe;
            md_e.pin  = (gpio_pin_out & md_lsel) | (m_drive & ~md_lsel);
            md_accept = pat_valid && (pq.size() < PD);
            if (m_holding && m_left > 0) begin
                m_left--;
            end else if (pq.size() > 0) begin
                m_drive   = pq[0].data;
                m_left    = int'(pq[0].hold);
                m_holding = 1'b1;
                void'(pq.pop_front());
            end else begin
                m_holding = 1'b0;
            end
            if (md_accept) pq.push_back({pat_hold, pat_data});
            md_e.busy  = m_holding || (pq.size() > 0);
            md_e.ready = (pq.size() < PD);
            cycq.push_back(md_e);

            md_drv  = gpio_pin_out & ~n_gpio_pin_oe;
            md_msk  = ~n_gpio_pin_oe;
            md_cpop = cap_ready && (m_cap_count > 0);
            if (CAP_ON != 0 && (md_drv != m_prev_drv || md_msk != m_prev_msk)) begin
                if (m_cap_count - int'(md_cpop) < CD) begin
                    md_ce.data = md_drv;
                    md_ce.mask = md_msk;
                    capq.push_back(md_ce);
                    m_cap_count++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (md_cpop) m_cap_count--;
            m_prev_drv = md_drv;
            m_prev_msk = md_msk;
        end
    end

    cyc_t       mon_e;
    cap_entry_t mon_ce;

    always @(negedge pclk) begin
        if (p_reset) begin
            cycq.delete();
        end else begin
            if (cycq.size() > 0) begin
                mon_e = cycq.pop_front();
                checkOutput("gpio_pin_in", 64'(gpio_pin_in), 64'(mon_e.pin));
                checkOutput("busy", 64'(busy), 64'(mon_e.busy));
                checkOutput("pat_ready", 64'(pat_ready), 64'(mon_e.ready));
            end
            checkOutput("cap_valid", 64'(cap_valid), 64'(m_cap_count > 0));
            checkOutput("cap_overflow", 64'(cap_overflow), 64'(m_ovf));
            if (cap_valid && cap_ready) begin
                if (capq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL cap_unexpected got data=0x%0h mask=0x%0h expected no entry", cap_data, cap_mask);
                end else begin
                    mon_ce = capq.pop_front();
                    checkOutput("cap_data", 64'(cap_data), 64'(mon_ce.data));
                    checkOutput("cap_mask", 64'(cap_mask), 64'(mon_ce.mask));
                    cap_pops++;
                end
            end
        end
    end

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic lb, input logic [DW-1:0] oe, input logic [DW-1:0] out);
        loopback_en   = lb;
        n_gpio_pin_oe = oe;
        gpio_pin_out  = out;
        stepCycles(1);
    endtask

    task automatic pushPattern(input logic [DW-1:0] d, input logic [HW-1:0] h, output int waited);
        pat_data  = d;
        pat_hold  = h;
        pat_valid = 1'b1;
        waited    = 0;
        @(negedge pclk);
        while (!pat_ready && waited < 600) begin
            waited++;
            @(negedge pclk);
        end
        if (!pat_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL push_timeout got pat_ready=0 after %0d cycles expected 1", waited);
        end
        @(posedge pclk);
        #1;
        pat_valid = 1'b0;
    endtask

    task automatic patternStream(input string tag);
        int w;
        pushPattern(32'hA5A5_0001, 8'd0, w);
        pushPattern(32'h0000_FFFF, 8'd2, w);
        stepCycles(1);
        checkOutput({tag, "_first"}, 64'(gpio_pin_in), 64'h0000_0000_A5A5_0001);
        stepCycles(1);
        checkOutput({tag, "_second"}, 64'(gpio_pin_in), 64'h0000_0000_0000_FFFF);
        stepCycles(5);
        checkOutput({tag, "_held"}, 64'(gpio_pin_in), 64'h0000_0000_0000_FFFF);
        checkOutput({tag, "_busy_low"}, 64'(busy), 64'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_pin_in"}, 64'(gpio_pin_in), 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_pat_ready"}, 64'(pat_ready), 64'd1);
        checkOutput({tag, "_cap_valid"}, 64'(cap_valid), 64'd0);
        checkOutput({tag, "_cap_data"}, 64'(cap_data), 64'd0);
        checkOutput({tag, "_cap_mask"}, 64'(cap_mask), 64'd0);
        checkOutput({tag, "_cap_overflow"}, 64'(cap_overflow), 64'd0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;
        int n0;
        p_reset       = 1'b1;
        loopback_en   = 1'b0;
        n_gpio_pin_oe = '1;
        gpio_pin_out  = '0;
        pat_valid     = 1'b0;
        pat_data      = '0;
        pat_hold      = '0;
        cap_ready     = 1'b1;
        stepCycles(2);
        checkResetValues("reset");
        p_reset = 1'b0;

        patternStream("stream");

        pushPattern(32'hFFFF_FFFF, 8'd0, w);
        stepCycles(4);
        applyStimulus(1'b1, 32'hFFFF_0000, 32'h1234_5678);
        checkOutput("loopback", 64'(gpio_pin_in), 64'h0000_0000_FFFF_5678);
        applyStimulus(1'b0, 32'hFFFF_0000, 32'h1234_5678);
        checkOutput("loopback_off", 64'(gpio_pin_in), 64'h0000_0000_FFFF_FFFF);

        applyStimulus(1'b0, 32'h0, 32'h0);
        stepCycles(3);
        n0 = cap_pops;
        applyStimulus(1'b0, 32'h0, 32'h1);
        applyStimulus(1'b0, 32'h0, 32'h1);
        applyStimulus(1'b0, 32'h0, 32'h3);
        stepCycles(3);
        checkOutput("capture_pair", 64'(cap_pops - n0), 64'(2 * CAP_ON));
        applyStimulus(1'b0, '1, 32'h3);
        stepCycles(3);
        checkOutput("capture_mask_off", 64'(cap_pops - n0), 64'(3 * CAP_ON));

        applyStimulus(1'b0, 32'h0, 32'h0);
        stepCycles(3);
        cap_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 32'h0, (i % 2 == 0) ? 32'h1 : 32'h0);
        end
        stepCycles(1);
        checkOutput("overflow_set", 64'(cap_overflow), 64'(CAP_ON));
        n0        = cap_pops;
        cap_ready = 1'b1;
        stepCycles(12);
        checkOutput("overflow_kept", 64'(cap_pops - n0), 64'(8 * CAP_ON));
        checkOutput("overflow_sticky", 64'(cap_overflow), 64'(CAP_ON));
        p_reset = 1'b1;
        #1;
        checkOutput("overflow_cleared", 64'(cap_overflow), 64'd0);
        @(posedge pclk);
        #1;
        p_reset = 1'b0;

        pushPattern(32'hC0DE_0000, 8'd255, w);
        stepCycles(1);
        for (int k = 1; k <= 4; k++) begin
            pushPattern(DW'(k), 8'd0, w);
        end
        checkOutput("pat_full_ready", 64'(pat_ready), 64'd0);
        pushPattern(32'h0000_0005, 8'd0, w);
        checkOutput("pat_full_wait", 64'(w > 200), 64'd1);
        stepCycles(10);

        pushPattern(32'hDEAD_BEEF, 8'd50, w);
        stepCycles(10);
        @(negedge pclk);
        #2;
        p_reset = 1'b1;
        #1;
        checkResetValues("midhold");
        @(posedge pclk);
        #1;
        p_reset = 1'b0;
        patternStream("restream");

        for (int c = 0; c < 400; c++) begin
            pat_valid = ($urandom_range(0, 2) == 0);
            pat_data  = $urandom;
            pat_hold  = HW'($urandom_range(0, 3));
            cap_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0:       n_gpio_pin_oe = '0;
                    1:       n_gpio_pin_oe = '1;
                    default: n_gpio_pin_oe = $urandom;
                endcase
            end
            if ($urandom_range(0, 1) == 1) gpio_pin_out = $urandom;
            loopback_en = 1'($urandom_range(0, 1));
            stepCycles(1);
        end
        pat_valid = 1'b0;
        cap_ready = 1'b1;
        stepCycles(40);
        checkOutput("final_busy", 64'(busy), 64'd0);
        checkOutput("final_cap_valid", 64'(cap_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpio_pad_responder.md
# gpio_pad_responder

Pin-side responder for the GPIO pad bus: the far end of the `n_gpio_pin_oe` / `gpio_pin_out` / `gpio_pin_in` signal group.
- It drives `gpio_pin_in` either from a queued pattern stream or by per-bit loopback of enabled outputs.
- It captures every change of the driven output pins into a pop-side queue.
- It sits opposite the GPIO controller in cluster-level benches and emulation builds, clocked by the APB clock.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: pin bus width; equals the project GPIO data-width define.
- `HOLD_WIDTH`, default 8: width of the per-pattern hold count.
- `PAT_DEPTH`, default 4: pattern FIFO depth; must be a power of 2, ≥2.
- `CAP_DEPTH`, default 8: capture FIFO depth; must be a power of 2, ≥2.

Ports:
- `pclk`  in  1  system clock; all state on rising edge.
- `p_reset`  in  1  reset, asynchronous, active-high.
- `n_gpio_pin_oe`  in  DATA_WIDTH  per-bit output enable from controller, active-low.
- `gpio_pin_out`  in  DATA_WIDTH  controller output data.
- `gpio_pin_in`  out  DATA_WIDTH  registered input data presented to controller.
- `loopback_en`  in  1  enables per-bit loopback of driven outputs.
- `pat_valid`  in  1  pattern push request.
- `pat_ready`  out  1  pattern FIFO not full.
- `pat_data`  in  DATA_WIDTH  pattern value.
- `pat_hold`  in  HOLD_WIDTH  extra cycles to hold the value.
- `cap_valid`  out  1  capture FIFO not empty (first-word-fall-through).
- `cap_ready`  in  1  capture pop.
- `cap_data`  out  DATA_WIDTH  captured `gpio_pin_out & ~n_gpio_pin_oe`.
- `cap_mask`  out  DATA_WIDTH  captured `~n_gpio_pin_oe`.
- `cap_overflow`  out  1  sticky: a capture event was dropped.
- `busy`  out  1  pattern FSM in HOLD or pattern FIFO non-empty.

## Operation
- **Push:** occurs when `pat_valid && pat_ready`. `pat_ready = !full`, so a push into a full FIFO is never accepted, even if a pop happens in the same cycle.
- **Pattern FSM, IDLE:**
  - If the FIFO is non-empty: pop, load `drive_reg <= pat_data`, load `cnt <= pat_hold`, go to HOLD.
  - Otherwise stay in IDLE; `drive_reg` keeps its last value.
- **Pattern FSM, HOLD:**
  - If `cnt != 0`: `cnt--`.
  - If `cnt == 0` and the FIFO is non-empty: pop and reload back-to-back, no gap.
  - If `cnt == 0` and the FIFO is empty: go to IDLE.
  - Each word is therefore held `pat_hold+1` cycles; `pat_hold = 0` gives one cycle.
- **Pin input, per bit i, registered every edge:**
  - `gpio_pin_in[i] <= (loopback_en && !n_gpio_pin_oe[i]) ? gpio_pin_out[i] : drive_reg[i]`.
- **Capture detection:**
  - `drv = gpio_pin_out & ~n_gpio_pin_oe`; `msk = ~n_gpio_pin_oe`.
  - Registers `drv_q` and `msk_q` hold the previous values.
  - An event fires when `drv != drv_q` or `msk != msk_q`; the event writes `{drv, msk}` to the capture FIFO.
- **Capture FIFO full:**
  - A full FIFO drops the event and sets `cap_overflow`.
  - A pop and a write in the same cycle while full succeed; no drop.
- **Overflow clear:** `cap_overflow` clears only on reset.
- **Simultaneous push and pop:** allowed on both FIFOs whenever not blocked by full/empty. Occupancy is unchanged.
- **Reset:** asserting `p_reset` at any time flushes both FIFOs and aborts HOLD; pending patterns are lost.
- **Output reset values:**
  - 0: `gpio_pin_in`, `cap_valid`, `cap_data`, `cap_mask`, `cap_overflow`, `busy`.
  - 1: `pat_ready`.
- **Internal reset values:** `drive_reg = 0`, `cnt = 0`, FSM = IDLE, `drv_q = 0`, `msk_q = 0`.

## Timing
- **Loopback:** a `gpio_pin_out` change sampled at edge E appears on `gpio_pin_in` after edge E (1 cycle).
- **Pattern:** push at edge E into an empty FIFO with the FSM in IDLE:
  - pop and load `drive_reg` at E+1;
  - `gpio_pin_in` updates at E+2;
  - `busy` rises after E.
- **Capture:** a change present before edge E is written at E; `cap_valid` and `cap_data` are valid after E.
- **Pointer wrap:** FIFO pointers are log2(depth)+1 bits wide and wrap modulo 2·depth. Full/empty is derived from the MSB and the remaining bits.
- **Hold counter:** never underflows; it is only decremented when non-zero.

## Configuration
- `GPIO_PAD_CAPTURE_EN` defined: the capture path (detector, `drv_q`/`msk_q`, capture FIFO) is compiled in.
- `GPIO_PAD_CAPTURE_EN` undefined: the capture path is compiled out.
  - `cap_valid`, `cap_data`, `cap_mask` and `cap_overflow` are tied to 0.
  - `cap_ready` is ignored.
  - The port list is unchanged.

## Structure
- **Package `gpio_pad_pkg`:**
  - FSM state enum `{PAD_IDLE, PAD_HOLD}`.
  - Default width/depth constants.
  - Packed struct `cap_entry_t {data, mask}`.
- **Sub-module `gpio_pad_fifo`:**
  - Parameterized synchronous FWFT FIFO with async active-high reset.
  - Instantiated for patterns (`{hold, data}`) and captures.

## Test plan
- **Pattern stream:** push 0xA5A5_0001 hold 0, then 0x0000_FFFF hold 2, `loopback_en = 0` -> `gpio_pin_in` shows 0xA5A5_0001 for 1 cycle, then 0x0000_FFFF for 3 cycles, then holds 0x0000_FFFF; `busy` falls once the FSM returns to IDLE.
- **Loopback:**
  - Setup: `loopback_en = 1`, `n_gpio_pin_oe = 0xFFFF_0000`, `gpio_pin_out = 0x1234_5678`, `drive_reg = 0xFFFF_FFFF`.
  - Required: `gpio_pin_in = 0xFFFF_5678` one cycle later.
- **Capture sequence:** with all bits enabled, `gpio_pin_out` goes 0 -> 1 -> 1 -> 3 -> exactly two entries (data 1, then 3, mask 0xFFFF_FFFF), then one more entry when `n_gpio_pin_oe` goes all-ones (data 0, mask 0).
- **Overflow:** hold `cap_ready = 0` and toggle bit 0 on 10 consecutive cycles, `CAP_DEPTH = 8` -> 8 entries kept, `cap_overflow = 1`. It stays 1 after draining and clears on reset.
- **Pattern FIFO full:** push 5 words with `PAT_DEPTH = 4` while the FSM holds `pat_hold = 255` -> `pat_ready` low after the 4th queued word; the 5th is not accepted until the first pop.
- **Reset mid-HOLD:** assert `p_reset` asynchronously mid-HOLD -> outputs immediately at reset values, FIFOs empty, FSM in IDLE; post-reset push behaves as in the first scenario.
